// File: rtl/axi4lite_csr_bridge.sv
// rtl/axi4lite_csr_bridge.sv - AXI4-Lite slave front-end issuing single-beat CSR request/ack transfers
//
// Purpose: captures AXI4-Lite AW, W and AR beats into one-entry slots and
// arbitrates round-robin between complete writes and reads. It decodes the
// address window, runs one CSR request at a time, and returns B/R responses.
// Out-of-window accesses never reach the CSR bus and complete with SLVERR.
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   s_axi_aw*             write address channel (awprot ignored)
//   s_axi_w*              write data channel
//   s_axi_b*              write response channel
//   s_axi_ar*             read address channel (arprot ignored)
//   s_axi_r*              read data channel
//   csr_req/wr/addr/      CSR request; held stable until csr_ack
//   wdata/wstrb
//   csr_ack/rdata/err     CSR completion; rdata/err valid with csr_ack
//
// Build option: define AXI4LITE_CSR_TIMEOUT_EN to abandon a CSR request that
// has not been acknowledged within TIMEOUT_CYCLES cycles (SLVERR, rdata 0).

module axi4lite_csr_bridge #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    CSR_ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
  parameter int                    WINDOW_BYTES   = 4096,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      csr_req,
  output logic                      csr_wr,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0]     csr_wdata,
  output logic [DATA_WIDTH/8-1:0]   csr_wstrb,
  input  logic                      csr_ack,
  input  logic [DATA_WIDTH-1:0]     csr_rdata,
  input  logic                      csr_err
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]       WIN_LIMIT = (ADDR_WIDTH + 1)'(WINDOW_BYTES);
  localparam logic [CSR_ADDR_WIDTH-1:0] WORD_MASK = ~CSR_ADDR_WIDTH'(STRB - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (CSR_ADDR_WIDTH > ADDR_WIDTH) begin : g_bad_csr_addr_width
    $error("CSR_ADDR_WIDTH must not exceed ADDR_WIDTH");
  end
  if (WINDOW_BYTES < 1 || (WINDOW_BYTES & (WINDOW_BYTES - 1)) != 0) begin : g_bad_window
    $error("WINDOW_BYTES must be a power of two");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_CSR_WR, S_CSR_RD, S_WR_RESP, S_RD_RESP} state_t;
  state_t state_q, state_d;

  // live_q keeps every ready low while in reset and for the reset edge itself
  logic                      live_q;
  logic                      aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_WIDTH-1:0]     aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]     w_data_q;
  logic [STRB-1:0]           w_strb_q;
  logic                      last_wr_q;
  logic                      hit_q;
  logic                      csr_wr_q;
  logic [CSR_ADDR_WIDTH-1:0] csr_addr_q;
  logic [DATA_WIDTH-1:0]     csr_wdata_q;
  logic [STRB-1:0]           csr_wstrb_q;
  logic [1:0]                resp_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

  logic                  aw_hs_c, w_hs_c, ar_hs_c;
  logic                  wr_elig_c, rd_elig_c, grant_wr_c, grant_rd_c;
  logic [ADDR_WIDTH-1:0] req_addr_c, offset_c;
  logic                  in_win_c;
  logic                  in_csr_c, csr_done_c, tmo_c, req_c;
  logic                  unused_c;

  assign unused_c = ^{s_axi_awprot, s_axi_arprot};

  assign s_axi_awready = live_q && !aw_full_q;
  assign s_axi_wready  = live_q && !w_full_q;
  assign s_axi_arready = live_q && !ar_full_q;
  assign aw_hs_c = s_axi_awvalid && s_axi_awready;
  assign w_hs_c  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs_c = s_axi_arvalid && s_axi_arready;

  // Round-robin: on a tie the side not granted last time wins (reset = write first)
  assign wr_elig_c  = aw_full_q && w_full_q;
  assign rd_elig_c  = ar_full_q;
  assign grant_wr_c = (state_q == S_IDLE) && wr_elig_c && (!rd_elig_c || !last_wr_q);
  assign grant_rd_c = (state_q == S_IDLE) && rd_elig_c && !grant_wr_c;

  // Decode via the offset so BASE_ADDR+WINDOW_BYTES never has to be formed
  assign req_addr_c = grant_wr_c ? aw_addr_q : ar_addr_q;
  assign offset_c   = req_addr_c - BASE_ADDR;
  assign in_win_c   = (req_addr_c >= BASE_ADDR) && ({1'b0, offset_c} < WIN_LIMIT);

  // A miss still passes through CSR_WR/CSR_RD for one cycle with csr_req low,
  // which keeps miss and best-case hit responses on the same edge
  assign in_csr_c   = (state_q == S_CSR_WR) || (state_q == S_CSR_RD);
  assign csr_done_c = in_csr_c && (!hit_q || csr_ack || tmo_c);

`ifdef AXI4LITE_CSR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !req_c) tmo_cnt_q <= '0;
    else               tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end

  // Fires in the TIMEOUT_CYCLES-th request cycle if no ack has come
  assign tmo_c = req_c && !csr_ack && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_c = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_wr_c)      state_d = S_CSR_WR;
        else if (grant_rd_c) state_d = S_CSR_RD;
      end
      S_CSR_WR:  if (csr_done_c)   state_d = S_WR_RESP;
      S_CSR_RD:  if (csr_done_c)   state_d = S_RD_RESP;
      S_WR_RESP: if (s_axi_bready) state_d = S_IDLE;
      S_RD_RESP: if (s_axi_rready) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_c        = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_rvalid = 1'b0;
    case (state_q)
      S_CSR_WR, S_CSR_RD: req_c        = hit_q;
      S_WR_RESP:          s_axi_bvalid = 1'b1;
      S_RD_RESP:          s_axi_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign csr_req     = req_c;
  assign csr_wr      = csr_wr_q;
  assign csr_addr    = csr_addr_q;
  assign csr_wdata   = csr_wdata_q;
  assign csr_wstrb   = csr_wstrb_q;
  assign s_axi_bresp = resp_q;
  assign s_axi_rresp = resp_q;
  assign s_axi_rdata = rdata_q;

  // Capture slots, request registers and response payload
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q      <= 1'b0;
      aw_full_q   <= 1'b0;
      w_full_q    <= 1'b0;
      ar_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      last_wr_q   <= 1'b0;
      hit_q       <= 1'b0;
      csr_wr_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wstrb_q <= '0;
      resp_q      <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      live_q <= 1'b1;
      if (aw_hs_c) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs_c) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (ar_hs_c) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= s_axi_araddr;
      end
      // Slots free as the transaction moves to its response state
      if (csr_done_c && state_q == S_CSR_WR) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
      if (csr_done_c && state_q == S_CSR_RD) begin
        ar_full_q <= 1'b0;
      end
      if (grant_wr_c || grant_rd_c) begin
        last_wr_q   <= grant_wr_c;
        hit_q       <= in_win_c;
        csr_wr_q    <= grant_wr_c;
        csr_addr_q  <= in_win_c ? (offset_c[CSR_ADDR_WIDTH-1:0] & WORD_MASK) : '0;
        csr_wdata_q <= grant_wr_c ? w_data_q : '0;
        csr_wstrb_q <= grant_wr_c ? w_strb_q : '0;
      end
      if (csr_done_c) begin
        resp_q  <= (hit_q && csr_ack && !csr_err) ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= (hit_q && csr_ack && !csr_wr_q) ? csr_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_csr_bridge.sv
// tb/tb_axi4lite_csr_bridge.sv - directed self-checking bench for axi4lite_csr_bridge
//
// Drives AXI4-Lite beats and the CSR ack side by hand, one cycle at a time;
// inputs change and outputs are sampled 1 ns after each rising edge.

module tb_axi4lite_csr_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        csr_req;
  logic        csr_wr;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_wstrb;
  logic        csr_ack;
  logic [31:0] csr_rdata;
  logic        csr_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi4lite_csr_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .CSR_ADDR_WIDTH(32),
    .BASE_ADDR(32'h4000_0000), .WINDOW_BYTES(4096), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .csr_req(csr_req), .csr_wr(csr_wr), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
    .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_err(csr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
  endtask

  task automatic take_b();
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
  endtask

  task automatic take_r();
    s_axi_rready = 1'b1; tick(); s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, csr_req, csr_wr} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
        {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, csr_req, csr_wr});
    end
    tests_run++;
    if ({csr_addr, csr_wdata, csr_wstrb, s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 104'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wdata=%h strb=%h bresp=%b rresp=%b rdata=%h expected all 0",
        csr_addr, csr_wdata, csr_wstrb, s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_write_same_cycle();
    drive_write(32'h4000_0000, 32'h0000_00EF, 4'hF);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tests_run++;
    if ({csr_req, s_axi_bvalid, s_axi_awready, s_axi_wready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wr_sc_after_capture: got req,bvalid,awready,wready=%b expected 0000",
        {csr_req, s_axi_bvalid, s_axi_awready, s_axi_wready});
    end
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr, csr_wdata, csr_wstrb} !== {2'b11, 32'h0, 32'h0000_00EF, 4'hF}) begin
      tests_failed++;
      $display("FAIL wr_sc_request: got req=%b wr=%b addr=%h wdata=%h strb=%h expected 1 1 00000000 000000ef f",
        csr_req, csr_wr, csr_addr, csr_wdata, csr_wstrb);
    end
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    tests_run++;
    if ({s_axi_bvalid, s_axi_bresp, csr_req, s_axi_awready} !== 5'b1_00_0_1) begin
      tests_failed++;
      $display("FAIL wr_sc_response: got bvalid=%b bresp=%b req=%b awready=%b expected 1 00 0 1",
        s_axi_bvalid, s_axi_bresp, csr_req, s_axi_awready);
    end
    take_b();
    tests_run++;
    if (s_axi_bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_sc_b_done: got bvalid=%b expected 0", s_axi_bvalid);
    end
  endtask

  task automatic test_w_before_aw();
    s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    tests_run++;
    if ({s_axi_wready, s_axi_awready, csr_req} !== 3'b010) begin
      tests_failed++;
      $display("FAIL w_first_slots: got wready,awready,req=%b expected 010", {s_axi_wready, s_axi_awready, csr_req});
    end
    tick(); tick();
    s_axi_awaddr = 32'h4000_0010; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    tests_run++;
    if (csr_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL w_first_no_early_req: got req=%b expected 0", csr_req);
    end
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr, csr_wdata, csr_wstrb} !== {2'b11, 32'h10, 32'h1234_5678, 4'h3}) begin
      tests_failed++;
      $display("FAIL w_first_request: got req=%b wr=%b addr=%h wdata=%h strb=%h expected 1 1 00000010 12345678 3",
        csr_req, csr_wr, csr_addr, csr_wdata, csr_wstrb);
    end
    tick();
    tests_run++;
    if ({csr_req, csr_addr, csr_wdata, s_axi_bvalid} !== {1'b1, 32'h10, 32'h1234_5678, 1'b0}) begin
      tests_failed++;
      $display("FAIL w_first_hold: got req=%b addr=%h wdata=%h bvalid=%b expected 1 00000010 12345678 0",
        csr_req, csr_addr, csr_wdata, s_axi_bvalid);
    end
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    tests_run++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b1_00) begin
      tests_failed++;
      $display("FAIL w_first_response: got bvalid=%b bresp=%b expected 1 00", s_axi_bvalid, s_axi_bresp);
    end
    take_b();
  endtask

  task automatic test_read_in_window();
    s_axi_araddr = 32'h4000_0FFF; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr} !== {2'b10, 32'h0000_0FFC}) begin
      tests_failed++;
      $display("FAIL rd_last_word_request: got req=%b wr=%b addr=%h expected 1 0 00000ffc", csr_req, csr_wr, csr_addr);
    end
    csr_ack = 1'b1; csr_rdata = 32'hCAFE_F00D;
    tick();
    csr_ack = 1'b0; csr_rdata = 32'h0;
    tick();
    tests_run++;
    if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {3'b1_00, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL rd_last_word_response: got rvalid=%b rresp=%b rdata=%h expected 1 00 cafef00d",
        s_axi_rvalid, s_axi_rresp, s_axi_rdata);
    end
    take_r();
  endtask

  task automatic test_read_out_of_window();
    s_axi_araddr = 32'hFFFF_FFFC; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    tests_run++;
    if ({csr_req, s_axi_rvalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rd_miss_gap: got req=%b rvalid=%b expected 0 0", csr_req, s_axi_rvalid);
    end
    tick();
    tests_run++;
    if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata, csr_req} !== {3'b1_10, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rd_miss_response: got rvalid=%b rresp=%b rdata=%h req=%b expected 1 10 00000000 0",
        s_axi_rvalid, s_axi_rresp, s_axi_rdata, csr_req);
    end
    take_r();
  endtask

  task automatic test_window_edges();
    logic [31:0] addrs [2];
    addrs[0] = 32'h4000_1000;
    addrs[1] = 32'h3FFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      drive_write(addrs[i], 32'h55, 4'hF);
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      tick();
      tests_run++;
      if ({csr_req, s_axi_bvalid} !== 2'b00) begin
        tests_failed++;
        $display("FAIL wr_miss_gap[%0h]: got req=%b bvalid=%b expected 0 0", addrs[i], csr_req, s_axi_bvalid);
      end
      tick();
      tests_run++;
      if ({s_axi_bvalid, s_axi_bresp, csr_req} !== 4'b1_10_0) begin
        tests_failed++;
        $display("FAIL wr_miss_response[%0h]: got bvalid=%b bresp=%b req=%b expected 1 10 0",
          addrs[i], s_axi_bvalid, s_axi_bresp, csr_req);
      end
      take_b();
    end
  endtask

  task automatic test_wstrb_zero();
    drive_write(32'h4000_0004, 32'h99, 4'h0);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr, csr_wstrb} !== {2'b11, 32'h4, 4'h0}) begin
      tests_failed++;
      $display("FAIL wstrb0_request: got req=%b wr=%b addr=%h strb=%h expected 1 1 00000004 0",
        csr_req, csr_wr, csr_addr, csr_wstrb);
    end
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    tests_run++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b1_00) begin
      tests_failed++;
      $display("FAIL wstrb0_response: got bvalid=%b bresp=%b expected 1 00", s_axi_bvalid, s_axi_bresp);
    end
    take_b();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    drive_write(32'h4000_0020, 32'h11, 4'hF);
    s_axi_araddr = 32'h4000_0024; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr} !== {2'b11, 32'h20}) begin
      tests_failed++;
      $display("FAIL arb_grant1_write: got req=%b wr=%b addr=%h expected 1 1 00000020", csr_req, csr_wr, csr_addr);
    end
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    drive_write(32'h4000_0028, 32'h22, 4'hF);
    s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr} !== {2'b10, 32'h24}) begin
      tests_failed++;
      $display("FAIL arb_grant2_read: got req=%b wr=%b addr=%h expected 1 0 00000024", csr_req, csr_wr, csr_addr);
    end
    csr_ack = 1'b1; csr_rdata = 32'h0000_A5A5;
    tick();
    csr_ack = 1'b0; csr_rdata = 32'h0;
    s_axi_araddr = 32'h4000_002C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr, csr_wdata} !== {2'b11, 32'h28, 32'h22}) begin
      tests_failed++;
      $display("FAIL arb_grant3_write: got req=%b wr=%b addr=%h wdata=%h expected 1 1 00000028 00000022",
        csr_req, csr_wr, csr_addr, csr_wdata);
    end
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    take_b();
    tick();
    tests_run++;
    if ({csr_req, csr_wr, csr_addr} !== {2'b10, 32'h2C}) begin
      tests_failed++;
      $display("FAIL arb_grant4_read: got req=%b wr=%b addr=%h expected 1 0 0000002c", csr_req, csr_wr, csr_addr);
    end
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    take_r();
  endtask

  task automatic test_wait_err();
    int req_cycles;
    req_cycles = 0;
    s_axi_araddr = 32'h4000_0100; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (csr_req === 1'b1 && csr_addr === 32'h100) req_cycles++;
      tick();
    end
    if (csr_req === 1'b1 && csr_addr === 32'h100) req_cycles++;
    tests_run++;
    if (req_cycles != 5) begin
      tests_failed++;
      $display("FAIL wait_req_held: got %0d stable req cycles expected 5", req_cycles);
    end
    csr_ack = 1'b1; csr_err = 1'b1;
    tick();
    csr_ack = 1'b0; csr_err = 1'b0;
    tick(); tick();
    tests_run++;
    if ({s_axi_rvalid, s_axi_rresp, csr_req} !== 4'b1_10_0) begin
      tests_failed++;
      $display("FAIL wait_err_response: got rvalid=%b rresp=%b req=%b expected 1 10 0",
        s_axi_rvalid, s_axi_rresp, csr_req);
    end
    take_r();
  endtask

`ifdef AXI4LITE_CSR_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    drive_write(32'h4000_0040, 32'h77, 4'hF);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (csr_req === 1'b1) req_cycles++;
      if (s_axi_bvalid === 1'b1) break;
    end
    tests_run++;
    if ({req_cycles, s_axi_bvalid, s_axi_bresp} !== {32'd4, 3'b1_10}) begin
      tests_failed++;
      $display("FAIL timeout_response: got req_cycles=%0d bvalid=%b bresp=%b expected 4 1 10",
        req_cycles, s_axi_bvalid, s_axi_bresp);
    end
    take_b();
    csr_ack = 1'b1;
    tick();
    csr_ack = 1'b0;
    tick();
    tests_run++;
    if ({csr_req, s_axi_bvalid, s_axi_rvalid, s_axi_awready} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL timeout_late_ack: got req,bvalid,rvalid,awready=%b expected 0001",
        {csr_req, s_axi_bvalid, s_axi_rvalid, s_axi_awready});
    end
  endtask
`endif

  task automatic test_reset_mid();
    drive_write(32'h4000_0080, 32'hAB, 4'hF);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    tests_run++;
    if (csr_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre_req: got req=%b expected 1", csr_req);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, csr_req,
         csr_addr, csr_wdata, csr_wstrb} !== 74'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got rdy=%b bv=%b rv=%b req=%b addr=%h wdata=%h strb=%h expected all 0",
        {s_axi_awready, s_axi_wready, s_axi_arready}, s_axi_bvalid, s_axi_rvalid, csr_req,
        csr_addr, csr_wdata, csr_wstrb);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, csr_req, s_axi_bvalid} !== 5'b111_00) begin
      tests_failed++;
      $display("FAIL rst_mid_release: got rdy=%b req=%b bvalid=%b expected 111 0 0",
        {s_axi_awready, s_axi_wready, s_axi_arready}, csr_req, s_axi_bvalid);
    end
    tick(); tick();
    tests_run++;
    if ({csr_req, s_axi_bvalid, s_axi_rvalid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_mid_dropped: got req=%b bvalid=%b rvalid=%b expected 0 0 0",
        csr_req, s_axi_bvalid, s_axi_rvalid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    csr_ack = 1'b0; csr_rdata = '0; csr_err = 1'b0;

    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_in_window();
    test_read_out_of_window();
    test_window_edges();
    test_wstrb_zero();
    test_back_to_back();
    test_wait_err();
`ifdef AXI4LITE_CSR_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
